// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with a two-flop row synchroniser and scan-level debounce.
// Latency: one accepted press or release takes DEBOUNCE_SCANS full scans plus 2 sync cycles.
// No backpressure: key/key_valid are level outputs and key_strobe is a single-cycle pulse.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_e;

  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_sync_q, row_sync_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [11:0]   samp_q, samp_d;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          key_strobe_q, key_strobe_d;

  logic          slot_last;
  logic          scan_end;
  logic [15:0]   scan_rows;
  logic [4:0]    zero_cnt;
  logic [3:0]    hit_idx;
  result_e       result;
  logic [3:0]    result_code;
  logic [3:0]    cnt_inc;

  // Map a (row, column) position to the key code printed on the keypad
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Synchroniser, slot timer, column rotation and per-column row samples
  always_comb begin
    row_meta_d = row_n;
    row_sync_d = row_meta_q;
    slot_last  = (slot_q == SW'(SCAN_DIV - 1));
    scan_end   = slot_last && (col_q == 2'd3);
    slot_d     = slot_last ? '0 : slot_q + 1'b1;
    col_d      = slot_last ? col_q + 2'd1 : col_q;
    samp_d     = samp_q;
    if (slot_last && (col_q != 2'd3)) begin
      samp_d[col_q*4 +: 4] = row_sync_q;
    end
  end

  // Resolve the four column samples into NONE / SINGLE(code) / MULTI;
  // column 3 is taken straight from the synchroniser on the scan-end edge
  always_comb begin
    scan_rows = {row_sync_q, samp_q};
    zero_cnt  = '0;
    hit_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (!scan_rows[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        hit_idx  = 4'(i);
      end
    end
    result_code = key_code(hit_idx[1:0], hit_idx[3:2]);
    if (zero_cnt == 5'd0) begin
      result = RES_NONE;
    end else if (zero_cnt == 5'd1) begin
      result = RES_SINGLE;
    end else begin
      result = RES_MULTI;
    end
  end

  // Debounce next-state: transitions only on the edge that completes a scan
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    cnt_inc = cnt_q + 4'd1;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (result == RES_SINGLE) begin
            state_d = PRESS_DEB;
            cand_d  = result_code;
            cnt_d   = 4'd1;
          end
        end
        PRESS_DEB: begin
          if (result == RES_SINGLE) begin
            if (result_code == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
                state_d = HELD;
              end
            end else begin
              cand_d = result_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (result == RES_NONE) begin
            state_d = RELEASE_DEB;
            cnt_d   = 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          if (result == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
  end

  // Outputs follow the debounce transitions: accept a press, or drop valid on release
  always_comb begin
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    key_strobe_d = 1'b0;
    if ((state_q == PRESS_DEB) && (state_d == HELD)) begin
      key_d        = cand_q;
      key_valid_d  = 1'b1;
      key_strobe_d = 1'b1;
    end else if ((state_q == RELEASE_DEB) && (state_d == IDLE)) begin
      key_valid_d = 1'b0;
    end
  end

  // State register for scanner, debounce FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      slot_q       <= '0;
      col_q        <= 2'd0;
      samp_q       <= 12'hFFF;
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cand_q       <= 4'd0;
      key_q        <= 4'd0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      row_meta_q   <= row_meta_d;
      row_sync_q   <= row_sync_d;
      slot_q       <= slot_d;
      col_q        <= col_d;
      samp_q       <= samp_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  // Column drive decodes straight from the column flop so reset shows at once
  always_comb begin
    col_n = ~(4'b0001 << col_q);
  end

  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad.
// Uses SCAN_DIV=4, DEBOUNCE_SCANS=3, so one full scan is 16 cycles.
// Key changes are applied just after scan-end edges so each scan sees a stable pattern.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_strobe;

  logic [15:0] pressed;
  int          n_tests;
  int          n_fail;
  int          strobe_cnt = 0;
  int          base;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to the active column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Count strobe cycles away from the active edge
  always @(negedge clk) begin
    if (rst_n && key_strobe) strobe_cnt = strobe_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n * 16) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r*4+c] = v;
  endtask

  // Clean press and release of one key, checking code, single strobe and release
  task automatic press_release(input string tag, input int r, input int c, input int code);
    base = strobe_cnt;
    set_key(r, c, 1'b1);
    wait_scans(2);
    check({tag, "_early_strobe"}, strobe_cnt - base, 0);
    wait_scans(1);
    check({tag, "_strobe"}, int'(key_strobe), 1);
    check({tag, "_key"}, int'(key), code);
    check({tag, "_valid"}, int'(key_valid), 1);
    wait_scans(1);
    check({tag, "_strobe_cnt"}, strobe_cnt - base, 1);
    set_key(r, c, 1'b0);
    wait_scans(3);
    check({tag, "_released"}, int'(key_valid), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pressed = '0;
    rst_n   = 1'b0;
    #12;
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key", int'(key), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_strobe", int'(key_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Column rotation over the first scan
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] e;
      repeat (4) @(posedge clk);
      #1;
      e = 4'b0001 << (i % 4);
      e = ~e;
      check("col_rot", int'(col_n), int'(e));
    end

    // Clean press of '5', held 10 scans, then released
    base = strobe_cnt;
    set_key(1, 1, 1'b1);
    wait_scans(2);
    check("k5_early", strobe_cnt - base, 0);
    check("k5_early_valid", int'(key_valid), 0);
    wait_scans(1);
    check("k5_strobe", int'(key_strobe), 1);
    check("k5_key", int'(key), 5);
    check("k5_valid", int'(key_valid), 1);
    wait_scans(7);
    check("k5_no_repeat", strobe_cnt - base, 1);
    set_key(1, 1, 1'b0);
    wait_scans(2);
    check("k5_rel_early", int'(key_valid), 1);
    wait_scans(1);
    check("k5_rel_valid", int'(key_valid), 0);
    check("k5_rel_key", int'(key), 5);

    // Bouncing '9' for 6 scans, then held stable
    base = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      set_key(2, 2, (i % 2) == 0);
      wait_scans(1);
    end
    check("k9_bounce_strobe", strobe_cnt - base, 0);
    check("k9_bounce_valid", int'(key_valid), 0);
    set_key(2, 2, 1'b1);
    wait_scans(2);
    check("k9_early", strobe_cnt - base, 0);
    wait_scans(1);
    check("k9_strobe", int'(key_strobe), 1);
    check("k9_key", int'(key), 9);
    wait_scans(1);
    check("k9_strobe_cnt", strobe_cnt - base, 1);
    set_key(2, 2, 1'b0);
    wait_scans(3);
    check("k9_released", int'(key_valid), 0);

    // Ghosting: '1' and '2' together, then '2' released
    base = strobe_cnt;
    set_key(0, 0, 1'b1);
    set_key(0, 1, 1'b1);
    wait_scans(8);
    check("ghost_strobe", strobe_cnt - base, 0);
    check("ghost_valid", int'(key_valid), 0);
    set_key(0, 1, 1'b0);
    wait_scans(2);
    check("ghost_early", strobe_cnt - base, 0);
    wait_scans(1);
    check("ghost_k1_strobe", int'(key_strobe), 1);
    check("ghost_k1_key", int'(key), 1);
    set_key(0, 0, 1'b0);
    wait_scans(3);
    check("ghost_released", int'(key_valid), 0);

    // Code map corners
    press_release("hash", 3, 2, 15);
    press_release("keyA", 0, 3, 10);
    press_release("star", 3, 0, 14);
    press_release("zero", 3, 1, 0);

    // Reset while '7' is held
    base = strobe_cnt;
    set_key(2, 0, 1'b1);
    wait_scans(3);
    check("k7_strobe", int'(key_strobe), 1);
    check("k7_key", int'(key), 7);
    wait_scans(1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_col_n", int'(col_n), 4'b1110);
    check("mid_rst_key", int'(key), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = strobe_cnt;
    wait_scans(2);
    check("k7_re_early", strobe_cnt - base, 0);
    wait_scans(1);
    check("k7_re_strobe", int'(key_strobe), 1);
    check("k7_re_key", int'(key), 7);
    check("k7_re_valid", int'(key_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and produces a debounced 4-bit key code. This stage sits directly upstream of the 7-segment key decoder, which consumes `key`. The block drives one column low at a time, samples the active-low rows through a synchroniser, and resolves each full scan to one of three results: no key, single key, or multiple keys. A debounce state machine accepts a new press, or a release, only after a configurable number of identical consecutive scans.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven per slot (legal range >= 4).
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or a release (legal range 2..15).

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
row_n  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk
col_n  output  4  keypad column drive; one-hot active-low
key  output  4  last accepted key code; held until the next accepted press
key_valid  output  1  high while the accepted key is considered held
key_strobe  output  1  one-cycle pulse when a new press is accepted

Behaviour:
- Reset (async assert, sync release):
  - col_n = 4'b1110 (column 0 active); key = 0; key_valid = 0; key_strobe = 0.
  - State IDLE; slot, column and debounce counters = 0; candidate = 0.
  - Row synchroniser flops reset to 4'b1111.
- Synchroniser: row_n passes through 2 flops. All sampling uses the synchroniser output.
- Scan timing:
  - Column c (0..3) is driven for SCAN_DIV cycles, then the block advances to c+1, wrapping 3 -> 0.
  - The full scan period is 4*SCAN_DIV cycles.
  - Rows are sampled on the last cycle of each column slot.
  - A pressed key at row r, column c reads as bit r = 0 in that column's sample.
- Scan result: evaluated on the clock edge that ends column 3's slot, using all four samples.
  - No zero bit in any sample -> NONE.
  - Exactly one zero bit in total -> SINGLE(code).
  - Otherwise -> MULTI.
- Key code map, rows top to bottom, columns left to right:
  - Row 0: 1, 2, 3, A=10.
  - Row 1: 4, 5, 6, B=11.
  - Row 2: 7, 8, 9, C=12.
  - Row 3: *=14, 0, #=15, D=13.
- State machine: cnt is the debounce counter. Transitions happen only at scan-end edges; outputs are registered.
  - IDLE:
    - SINGLE(k) -> PRESS_DEB, cand = k, cnt = 1.
    - NONE or MULTI -> stay in IDLE.
  - PRESS_DEB:
    - SINGLE(cand) -> cnt + 1. When the incremented value equals DEBOUNCE_SCANS -> HELD; on the same edge key = cand, key_valid = 1, key_strobe = 1.
    - SINGLE(k != cand) -> cand = k, cnt = 1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - Any SINGLE or MULTI -> stay in HELD, cnt = 0. No further strobe; there is no rollover or auto-repeat.
    - NONE -> RELEASE_DEB, cnt = 1.
  - RELEASE_DEB:
    - NONE -> cnt + 1. When it equals DEBOUNCE_SCANS -> IDLE and key_valid = 0. key keeps its value.
    - SINGLE or MULTI -> HELD.
- key_strobe is high for exactly one clk cycle per accepted press and is low in every other cycle.
- Minimum press latency: DEBOUNCE_SCANS full scans after the first scan that sees the key, plus 2 cycles of synchroniser delay. Release latency follows the same rule.
- Asynchronous reset mid-operation immediately forces all reset values and aborts the scan. After reset release, a still-held key is treated as a new press.

Test Plan:
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 3, giving a 16-cycle scan. The bench keypad model pulls row r low while col_n[c] = 0 and key (r,c) is pressed.
- Reset/rotation: after reset, col_n = 1110 and all outputs are 0; col_n steps 1110 -> 1101 -> 1011 -> 0111 -> 1110 every 4 cycles.
- Clean press '5' (r1,c1) held 10 scans, then released:
  - One key_strobe pulse at the end of the 3rd scan that sees the key, with key = 5 and key_valid = 1.
  - No further strobes while held.
  - key_valid falls at the end of the 3rd NONE scan; key stays 5.
- Bounce: '9' alternates pressed/released on successive scans for 6 scans, then is held stable -> no strobe until 3 consecutive SINGLE(9) scans, then exactly one strobe with key = 9.
- Ghosting: '1' and '2' pressed together for 8 scans -> key_strobe is never asserted and key_valid stays 0. After '2' is released with '1' still held, a strobe occurs 3 scans later with key = 1.
- Code map: press '#' -> key = 15; 'A' -> key = 10; '*' -> key = 14; '0' -> key = 0. Each gives one strobe.
- Reset mid-HELD with '7' pressed:
  - rst_n low -> key = 0, key_valid = 0 and col_n = 1110 immediately, without waiting for a clock edge.
  - After rst_n goes high with '7' still held -> new strobe with key = 7 after 3 scans.
